axi4_lite_regfile: RTL and testbench
====================================

Name: axi4_lite_regfile

Overview:
- AXI4-lite slave register bank that sits directly downstream of axi4_lite_bus on one of its s_axi_* slave ports.
- Holds NUM_REGS software-writable registers, exposes their values and per-register write pulses to hardware, and answers reads with a 1-bit response (0 = OKAY, 1 = error).
- Only one write and one read are outstanding at a time. The write and read paths are independent.

Parameters:
- ADDR_WIDTH, 16, AXI address width; matches the bus.
- DATA_WIDTH, 16, AXI data width; must be a multiple of 8.
- NUM_REGS, 8, number of registers; must be ≥ 1.
- RESET_VALUE, '0, value loaded into every register on reset (DATA_WIDTH bits).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axi_awready  out  1  write-address ready
- s_axi_awvalid  in  1  write-address valid
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_wready  out  1  write-data ready
- s_axi_wvalid  in  1  write-data valid
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte enables
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_bresp  out  1  write response; 0 OKAY, 1 error
- s_axi_arready  out  1  read-address ready
- s_axi_arvalid  in  1  read-address valid
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_rready  in  1  read data ready
- s_axi_rvalid  out  1  read data valid
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  1  read response; 0 OKAY, 1 error
- reg_q  out  NUM_REGS x DATA_WIDTH  current register contents
- reg_wr  out  NUM_REGS  one-cycle pulse, set in the cycle after register i is committed

Behaviour:
- **Reset:**
  - All registers load RESET_VALUE.
  - aw_held, w_held, bvalid, rvalid, bresp, rresp and reg_wr all go to 0; rdata goes to 0.
  - awready, wready and arready are 1 in the first cycle after reset.
  - Reset mid-transaction drops the transaction silently: no response is issued and no register is written.
- **Address decode:**
  - Register index = addr[OFS +: IDX_W], where OFS = $clog2(DATA_WIDTH/8) and IDX_W = max(1, $clog2(NUM_REGS)).
  - Bits below OFS and above OFS+IDX_W are ignored; the upstream bus performs the base decode.
  - An index ≥ NUM_REGS is out of range.
- **Write path:**
  - awready = ~aw_held & ~bvalid; wready = ~w_held & ~bvalid.
  - An AW handshake latches the address and sets aw_held. A W handshake latches data and strobe and sets w_held.
  - AW and W may arrive in the same cycle or in either order, any number of cycles apart.
  - At the first edge where aw_held & w_held, the write commits:
    - In range: each byte b with wstrb[b]=1 updates; other bytes hold. reg_wr[idx] pulses for one cycle. bresp = 0.
    - Out of range: no register changes, no pulse, bresp = 1.
    - bvalid is set and both held flags clear.
  - Latency: from the later of the AW/W handshake edges, commit and bvalid occur one edge later.
  - bvalid stays high, and bresp stays stable, until a bready handshake. bvalid drops on that edge.
  - AW/W are re-accepted in the cycle after bvalid falls.
  - A write with all-zero wstrb still commits: reg_wr pulses, data is unchanged, bresp = 0.
- **Read path:**
  - arready = ~rvalid.
  - On an AR handshake edge, the block sets rvalid and loads rdata = reg[idx] with rresp = 0. If the index is out of range, it loads rdata = 0 with rresp = 1.
  - rvalid, rdata and rresp are held stable until an rready handshake. The next AR is accepted in the cycle after rvalid falls; there is no back-to-back acceptance.
  - rready may already be high when rvalid rises; the handshake then completes on the first rvalid cycle.
- **Read/write collision:** if an AR handshake and a write commit to the same register happen on the same edge, rdata returns the pre-write value.
- **Outputs:** reg_q is the registered value, so it reflects a commit one cycle after the commit edge, aligned with the reg_wr pulse.

Decomposition:
- Shared package axi4_lite_pkg:
  - RESP_OKAY = 1'b0, RESP_ERR = 1'b1 (also intended for the bus).
  - A function for the byte-strobe merge, apply_wstrb(old, new, strb).
- No sub-module is needed. The write-channel join (aw_held/w_held) stays inline; the block is about 200 lines of RTL.

Test Plan:
All scenarios use default parameters: DATA_WIDTH=16, NUM_REGS=8, index = addr[3:1].

- **Simultaneous AW/W:** AW 0x0004 and W 0xBEEF with strb 2'b11 in the same cycle, bready=1 → one cycle later reg_q[2]=0xBEEF, reg_wr=8'h04 for one cycle, bvalid=1 with bresp=0; then AR 0x0004 → rdata=0xBEEF, rresp=0.
- **W before AW, partial strobe:** W 0x1234 with strb 2'b01 at cycle 0, then AW 0x0000 at cycle 3 → reg_q[0] = {RESET_VALUE[15:8], 8'h34}; awready stays 1 until cycle 3; wready is 0 during cycles 1-3.
- **Out-of-range accesses (NUM_REGS=6):** write to 0x000C → bresp=1, no reg_wr, all reg_q unchanged; read of 0x000E → rdata=0, rresp=1.
- **Backpressure:** bready=0 for 5 cycles after a write → bvalid held, bresp stable, awready=wready=0 throughout; a second AW offered meanwhile is accepted only in the cycle after bready=1 and bvalid falls.
- **Read/write collision:** AR 0x0002 on the same edge as a commit of 0x5555 to reg 1 (old value 0x0000) → rdata=0x0000; a following read returns 0x5555.
- **Reset mid-operation:** reset asserted while aw_held=1 and rvalid=1 → next cycle bvalid=0, rvalid=0, all reg_q = RESET_VALUE, all ready signals = 1.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-lite definitions for the register bank and the upstream bus.
//   axi_resp_t   1-bit response code (RESP_OKAY / RESP_ERR)
//   apply_wstrb  byte-strobe merge of new write data into an old word; works
//                on words up to MAX_DATA_W bits, callers zero-extend and
//                truncate to their own data width.
package axi4_lite_pkg;

  typedef logic axi_resp_t;

  localparam axi_resp_t RESP_OKAY = 1'b0;
  localparam axi_resp_t RESP_ERR  = 1'b1;

  localparam int MAX_DATA_W = 256;
  localparam int MAX_STRB_W = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] apply_wstrb(
    input logic [MAX_DATA_W-1:0] old_data,
    input logic [MAX_DATA_W-1:0] new_data,
    input logic [MAX_STRB_W-1:0] strb
  );
    logic [MAX_DATA_W-1:0] merged;
    merged = old_data;
    for (int b = 0; b < MAX_STRB_W; b++) begin
      if (strb[b]) merged[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi4_lite_regfile_if.sv
// AXI4-lite channel bundle between a bus master port and a slave.
//   AW: awvalid/awready/awaddr     W: wvalid/wready/wdata/wstrb
//   B : bvalid/bready/bresp        AR: arvalid/arready/araddr
//   R : rvalid/rready/rdata/rresp
// Modports: master drives requests, slave drives readies and responses.
interface axi4_lite_regfile_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  import axi4_lite_pkg::*;

  logic                    awready;
  logic                    awvalid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wready;
  logic                    wvalid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  axi_resp_t               bresp;
  logic                    arready;
  logic                    arvalid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rready;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  axi_resp_t               rresp;

  modport master (
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4_lite_regfile.sv
// AXI4-lite slave register bank.
//   clk, reset  clock and synchronous active-high reset
//   s_axi       AXI4-lite slave port (one write and one read outstanding)
//   reg_q       current contents of all NUM_REGS registers
//   reg_wr      one-cycle pulse per register, high in the cycle after a commit
// Register index = addr[OFS +: IDX_W]; other address bits are decoded upstream.
// Out-of-range writes change nothing and answer RESP_ERR; out-of-range reads
// return zero with RESP_ERR.
module axi4_lite_regfile #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    NUM_REGS    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  axi4_lite_regfile_if.slave                  s_axi,
  output logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                 reg_wr
);
  import axi4_lite_pkg::*;

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS    = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                  aw_held;
  logic                  w_held;
  logic [IDX_W-1:0]      aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  bvalid_q;
  axi_resp_t             bresp_q;
  logic                  rvalid_q;
  axi_resp_t             rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  awready_c;
  logic                  wready_c;
  logic                  arready_c;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  wr_in_range;
  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_in_range;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_sel;

  // Only the index field matters here; the remaining address bits are
  // consumed by the upstream decoder.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.awaddr, s_axi.araddr};

  // Both address channels block while a response is pending, so a new
  // request can only be taken once the previous one has fully retired.
  assign awready_c = ~aw_held & ~bvalid_q;
  assign wready_c  = ~w_held & ~bvalid_q;
  assign arready_c = ~rvalid_q;

  assign aw_hs  = s_axi.awvalid & awready_c;
  assign w_hs   = s_axi.wvalid & wready_c;
  assign ar_hs  = s_axi.arvalid & arready_c;
  assign commit = aw_held & w_held;

  assign ar_idx      = s_axi.araddr[OFS +: IDX_W];
  assign wr_in_range = ({1'b0, aw_idx} < (IDX_W+1)'(NUM_REGS));
  assign ar_in_range = ({1'b0, ar_idx} < (IDX_W+1)'(NUM_REGS));

  assign s_axi.awready = awready_c;
  assign s_axi.wready  = wready_c;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_c;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  // ---- Write join: AW and W captured independently, commit when both held
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (aw_hs)       aw_held <= 1'b1;
      else if (commit) aw_held <= 1'b0;

      if (w_hs)        w_held <= 1'b1;
      else if (commit) w_held <= 1'b0;

      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_ERR;
      end else if (bvalid_q & s_axi.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_idx <= s_axi.awaddr[OFS +: IDX_W];
    if (w_hs) begin
      w_data <= s_axi.wdata;
      w_strb <= s_axi.wstrb;
    end
  end

  // ---- Commit: strobe-merge into the addressed register
  always_comb begin
    wr_old = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i)) wr_old = reg_q[i];
    end
  end

  assign wr_merged = DATA_WIDTH'(apply_wstrb(MAX_DATA_W'(wr_old),
                                             MAX_DATA_W'(w_data),
                                             MAX_STRB_W'(w_strb)));

  // An out-of-range index matches no register, so it neither writes nor pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= RESET_VALUE;
      reg_wr <= '0;
    end else begin
      reg_wr <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && (aw_idx == IDX_W'(i))) begin
          reg_q[i]  <= wr_merged;
          reg_wr[i] <= 1'b1;
        end
      end
    end
  end

  // ---- Read: capture on AR; sampling reg_q gives pre-write data on a collision
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_sel = reg_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= ar_in_range ? rd_sel : '0;
      rresp_q  <= ar_in_range ? RESP_OKAY : RESP_ERR;
    end else if (rvalid_q & s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Bench for axi4_lite_regfile: two instances driven in lockstep, one with the
// default 8 registers and one with 6 registers and a non-zero reset value, so
// the same traffic exercises both in-range and out-of-range behaviour.
module tb_axi4_lite_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [15:0] awaddr, wdata, araddr;
  logic [1:0]  wstrb;

  logic [7:0][15:0] q_a;
  logic [5:0][15:0] q_b;
  logic [7:0]       wr_a;
  logic [5:0]       wr_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain register arrays per instance.
  logic [15:0] m_regs [2][8];
  int          m_n    [2];
  logic [15:0] m_rst  [2];

  always #5 clk = ~clk;

  axi4_lite_regfile_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_a ();
  axi4_lite_regfile_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus_b ();

  assign bus_a.awvalid = awvalid;  assign bus_b.awvalid = awvalid;
  assign bus_a.awaddr  = awaddr;   assign bus_b.awaddr  = awaddr;
  assign bus_a.wvalid  = wvalid;   assign bus_b.wvalid  = wvalid;
  assign bus_a.wdata   = wdata;    assign bus_b.wdata   = wdata;
  assign bus_a.wstrb   = wstrb;    assign bus_b.wstrb   = wstrb;
  assign bus_a.bready  = bready;   assign bus_b.bready  = bready;
  assign bus_a.arvalid = arvalid;  assign bus_b.arvalid = arvalid;
  assign bus_a.araddr  = araddr;   assign bus_b.araddr  = araddr;
  assign bus_a.rready  = rready;   assign bus_b.rready  = rready;

  axi4_lite_regfile u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .s_axi  (bus_a),
    .reg_q  (q_a),
    .reg_wr (wr_a)
  );

  axi4_lite_regfile #(.NUM_REGS(6), .RESET_VALUE(16'hA5C3)) u_dut_b (
    .clk    (clk),
    .reset  (reset),
    .s_axi  (bus_b),
    .reg_q  (q_b),
    .reg_wr (wr_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                              input logic [1:0] strb);
    logic [15:0] mask;
    mask = {{8{strb[1]}}, {8{strb[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) m_regs[d][i] = m_rst[d];
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) check_val($sformatf("%s_a_q%0d", tag, i), 32'(q_a[i]), 32'(m_regs[0][i]));
    for (int i = 0; i < 6; i++) check_val($sformatf("%s_b_q%0d", tag, i), 32'(q_b[i]), 32'(m_regs[1][i]));
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_awready_a"}, 32'(bus_a.awready), 32'd1);
    check_val({tag, "_wready_a"},  32'(bus_a.wready),  32'd1);
    check_val({tag, "_arready_a"}, 32'(bus_a.arready), 32'd1);
    check_val({tag, "_awready_b"}, 32'(bus_b.awready), 32'd1);
    check_val({tag, "_wready_b"},  32'(bus_b.wready),  32'd1);
    check_val({tag, "_arready_b"}, 32'(bus_b.arready), 32'd1);
    check_val({tag, "_bvalid_a"},  32'(bus_a.bvalid),  32'd0);
    check_val({tag, "_bvalid_b"},  32'(bus_b.bvalid),  32'd0);
    check_val({tag, "_rvalid_a"},  32'(bus_a.rvalid),  32'd0);
    check_val({tag, "_rvalid_b"},  32'(bus_b.rvalid),  32'd0);
    check_val({tag, "_wr_a"},      32'(wr_a),          32'd0);
    check_val({tag, "_wr_b"},      32'(wr_b),          32'd0);
  endtask

  // Called and returns at a negedge. offer_aw keeps AW valid during the
  // response wait to show that it is not accepted early.
  task automatic do_write(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, input bit offer_aw);
    bit          aw_done, w_done, aw_fire, w_fire;
    int          cyc, idx;
    logic [31:0] exp_wr [2];
    logic        exp_resp [2];
    aw_done = 0; w_done = 0; cyc = 0;
    idx = int'(addr[3:1]);
    bready = 1'b0;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      check_val("wr_awready_a", 32'(bus_a.awready), 32'(!aw_done));
      check_val("wr_wready_a",  32'(bus_a.wready),  32'(!w_done));
      check_val("wr_awready_b", 32'(bus_b.awready), 32'(!aw_done));
      check_val("wr_wready_b",  32'(bus_b.wready),  32'(!w_done));
      aw_fire = awvalid && bus_a.awready;
      w_fire  = wvalid && bus_a.wready;
      @(negedge clk);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      cyc++;
      if (!(aw_done && w_done) && cyc > 50) begin
        check_val("wr_accept", 32'(aw_done && w_done), 32'd1);
        aw_done = 1; w_done = 1;
      end
    end
    awvalid = offer_aw;
    wvalid  = 1'b0;
    // Cycle between the last handshake and the commit edge.
    check_val("wr_pre_bvalid_a", 32'(bus_a.bvalid), 32'd0);
    check_val("wr_pre_awready_a", 32'(bus_a.awready), 32'd0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (idx < m_n[d]) begin
        m_regs[d][idx] = model_merge(m_regs[d][idx], data, strb);
        exp_wr[d]   = 32'd1 << idx;
        exp_resp[d] = 1'b0;
      end else begin
        exp_wr[d]   = 32'd0;
        exp_resp[d] = 1'b1;
      end
    end
    check_val("wr_bvalid_a", 32'(bus_a.bvalid), 32'd1);
    check_val("wr_bvalid_b", 32'(bus_b.bvalid), 32'd1);
    check_val("wr_bresp_a",  32'(bus_a.bresp),  32'(exp_resp[0]));
    check_val("wr_bresp_b",  32'(bus_b.bresp),  32'(exp_resp[1]));
    check_val("wr_pulse_a",  32'(wr_a), exp_wr[0]);
    check_val("wr_pulse_b",  32'(wr_b), exp_wr[1]);
    check_regs("wr");
    for (int k = 0; k < b_dly; k++) begin
      @(negedge clk);
      check_val("bp_bvalid_a",  32'(bus_a.bvalid),  32'd1);
      check_val("bp_bresp_b",   32'(bus_b.bresp),   32'(exp_resp[1]));
      check_val("bp_awready_a", 32'(bus_a.awready), 32'd0);
      check_val("bp_wready_b",  32'(bus_b.wready),  32'd0);
      check_val("bp_pulse_a",   32'(wr_a),          32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check_val("wr_done_bvalid_a",  32'(bus_a.bvalid),  32'd0);
    check_val("wr_done_bvalid_b",  32'(bus_b.bvalid),  32'd0);
    check_val("wr_done_awready_a", 32'(bus_a.awready), 32'd1);
    check_val("wr_done_wready_b",  32'(bus_b.wready),  32'd1);
    check_val("wr_done_pulse_a",   32'(wr_a),          32'd0);
  endtask

  // Called and returns at a negedge; r_dly < 0 raises rready together with AR.
  // The expected data is taken from the model 1 time unit after the negedge
  // before the AR edge, i.e. before any commit landing on that same edge.
  task automatic do_read(input logic [15:0] addr, input int ar_dly, input int r_dly);
    int          cyc, idx;
    bit          done;
    logic [15:0] exp_d [2];
    logic        exp_r [2];
    cyc = 0; done = 0;
    idx = int'(addr[3:1]);
    exp_d[0] = '0; exp_d[1] = '0; exp_r[0] = 1'b0; exp_r[1] = 1'b0;
    rready = (r_dly < 0);
    while (!done) begin
      arvalid = (cyc >= ar_dly);
      araddr  = addr;
      #1;
      check_val("rd_arready_a", 32'(bus_a.arready), 32'd1);
      check_val("rd_arready_b", 32'(bus_b.arready), 32'd1);
      if (arvalid && bus_a.arready) begin
        for (int d = 0; d < 2; d++) begin
          exp_r[d] = (idx >= m_n[d]);
          exp_d[d] = exp_r[d] ? 16'h0000 : m_regs[d][idx];
        end
        done = 1;
      end
      @(negedge clk);
      cyc++;
      if (!done && cyc > 50) begin
        check_val("rd_accept", 32'(done), 32'd1);
        done = 1;
      end
    end
    arvalid = 1'b0;
    check_val("rd_rvalid_a",  32'(bus_a.rvalid),  32'd1);
    check_val("rd_rvalid_b",  32'(bus_b.rvalid),  32'd1);
    check_val("rd_rdata_a",   32'(bus_a.rdata),   32'(exp_d[0]));
    check_val("rd_rdata_b",   32'(bus_b.rdata),   32'(exp_d[1]));
    check_val("rd_rresp_a",   32'(bus_a.rresp),   32'(exp_r[0]));
    check_val("rd_rresp_b",   32'(bus_b.rresp),   32'(exp_r[1]));
    check_val("rd_arready_lo", 32'(bus_a.arready), 32'd0);
    for (int k = 0; k < r_dly; k++) begin
      @(negedge clk);
      check_val("rd_hold_rvalid_a", 32'(bus_a.rvalid),  32'd1);
      check_val("rd_hold_rdata_b",  32'(bus_b.rdata),   32'(exp_d[1]));
      check_val("rd_hold_rresp_b",  32'(bus_b.rresp),   32'(exp_r[1]));
      check_val("rd_hold_arready",  32'(bus_a.arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    check_val("rd_done_rvalid_a",  32'(bus_a.rvalid),  32'd0);
    check_val("rd_done_rvalid_b",  32'(bus_b.rvalid),  32'd0);
    check_val("rd_done_arready_a", 32'(bus_a.arready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (n_tests=%0d)", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r_addr, r_data, r2_addr;
    logic [1:0]  r_strb;
    int          op;

    m_n[0] = 8;        m_n[1] = 6;
    m_rst[0] = 16'h0000; m_rst[1] = 16'hA5C3;
    reset = 1'b1;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = '0; wdata = '0; araddr = '0; wstrb = '0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_idle("rst");
    check_regs("rst");
    check_val("rst_rdata_a", 32'(bus_a.rdata), 32'd0);
    check_val("rst_bresp_b", 32'(bus_b.bresp), 32'd0);
    check_val("rst_rresp_b", 32'(bus_b.rresp), 32'd0);

    // Simultaneous AW/W, then read back
    do_write(16'h0004, 16'hBEEF, 2'b11, 0, 0, 0, 1'b0);
    do_read(16'h0004, 0, 0);

    // W three cycles before AW, low byte only
    do_write(16'h0000, 16'h1234, 2'b01, 3, 0, 0, 1'b0);
    // AW before W, high byte only, rready already high on the read
    do_write(16'h000A, 16'hC3A5, 2'b10, 0, 2, 1, 1'b0);
    do_read(16'h000A, 1, -1);

    // Out-of-range index on the 6-register instance
    do_write(16'h000C, 16'hDEAD, 2'b11, 0, 0, 0, 1'b0);
    do_read(16'h000E, 0, 2);

    // All-zero strobe still commits
    do_write(16'h0004, 16'hFFFF, 2'b00, 0, 0, 0, 1'b0);

    // Response backpressure with a second AW waiting
    do_write(16'h0006, 16'h1111, 2'b11, 0, 0, 5, 1'b1);
    do_write(16'h0008, 16'h2222, 2'b11, 0, 1, 0, 1'b0);

    // Read/write collision on register 1
    fork
      do_write(16'h0002, 16'h5555, 2'b11, 0, 0, 0, 1'b0);
      do_read(16'h0002, 1, 0);
    join
    do_read(16'h0002, 0, 0);

    // Reset with write join full and a read response pending
    awvalid = 1; awaddr = 16'h0006; wvalid = 1; wdata = 16'h7777; wstrb = 2'b11;
    arvalid = 1; araddr = 16'h0000;
    @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check_val("mid_rvalid_a", 32'(bus_a.rvalid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_idle("mid");
    check_regs("mid");
    @(negedge clk);
    check_idle("mid2");
    check_regs("mid2");

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      op      = $urandom_range(0, 2);
      r_addr  = 16'($urandom);
      r2_addr = 16'($urandom);
      r_data  = 16'($urandom);
      r_strb  = 2'($urandom);
      case (op)
        0: do_write(r_addr, r_data, r_strb, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'b0);
        1: do_read(r_addr, $urandom_range(0, 2), $urandom_range(0, 4) - 1);
        default: begin
          fork
            do_write(r_addr, r_data, r_strb, $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 2), 1'b0);
            do_read(r2_addr, $urandom_range(0, 3), $urandom_range(0, 3) - 1);
          join
        end
      endcase
    end
    check_regs("end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
